// File: rtl/fp_unpack_align.sv
// Operand front end for the single-precision adder: orders two packed words by magnitude,
// unpacks them, serially right-aligns the smaller significand and emits two's-complement operands.
module fp_unpack_align #(
    parameter int STEP      = 1,
    parameter int MAX_SHIFT = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] large_n,
    output logic [25:0] small_n,
    output logic        bit_r,
    output logic [7:0]  e,
    output logic        special
);

    localparam logic [7:0] STEP_W = 8'(STEP);
    localparam logic [7:0] MAX_W  = 8'(MAX_SHIFT);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [25:0] large_mag, small_mag;
    logic        large_sgn, small_sgn;
    logic [7:0]  cnt;

    function automatic logic [25:0] unpack_mag(input logic [31:0] x);
        return {1'b0, |x[30:23], x[22:0], 1'b0};
    endfunction

    // Zero and denormal operands share the exponent of the smallest normal.
    function automatic logic [7:0] eff_exp(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    endfunction

    function automatic logic signed [25:0] to_twos(input logic [25:0] m, input logic s);
        return s ? -$signed(m) : $signed(m);
    endfunction

    logic        a_is_large;
    logic [31:0] op_large, op_small;
    logic [7:0]  d, cnt_load;

    always_comb begin
        a_is_large = (a[30:0] >= b[30:0]);
        op_large   = a_is_large ? a : b;
        op_small   = a_is_large ? b : a;
        d          = eff_exp(op_large) - eff_exp(op_small);
        cnt_load   = (d > MAX_W) ? MAX_W : d;
    end

    logic [7:0]  k;
    logic [25:0] small_shr;
    logic        lost;
    logic signed [25:0] large_tc, small_tc;

    always_comb begin
        k         = (cnt < STEP_W) ? cnt : STEP_W;
        small_shr = small_mag >> k;
        lost      = |(small_mag & ((26'd1 << k) - 26'd1));
        large_tc  = to_twos(large_mag, large_sgn);
        small_tc  = to_twos(small_mag, small_sgn);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == 8'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            large_mag <= '0;
            small_mag <= '0;
            large_sgn <= 1'b0;
            small_sgn <= 1'b0;
            large_n   <= '0;
            small_n   <= '0;
            bit_r     <= 1'b0;
            e         <= '0;
            special   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    large_mag <= unpack_mag(op_large);
                    small_mag <= unpack_mag(op_small);
                    large_sgn <= op_large[31];
                    small_sgn <= op_small[31];
                    e         <= eff_exp(op_large);
                    special   <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
                    cnt       <= cnt_load;
                    bit_r     <= 1'b0;
                end
                SHIFT: if (cnt != 8'd0) begin
                    small_mag <= small_shr;
                    bit_r     <= bit_r | lost;
                    cnt       <= cnt - k;
                end else begin
                    large_n <= large_tc;
                    small_n <= small_tc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unpack_align.sv
// Directed bench: one STEP=1 and one STEP=4 instance share stimulus; results and latencies
// are compared against hand-computed values.
module tb_fp_unpack_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_ready;

    logic        in_ready_s1, out_valid_s1, bit_r_s1, special_s1;
    logic [25:0] large_n_s1, small_n_s1;
    logic [7:0]  e_s1;
    logic        in_ready_s4, out_valid_s4, bit_r_s4, special_s4;
    logic [25:0] large_n_s4, small_n_s4;
    logic [7:0]  e_s4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_unpack_align #(.STEP(1), .MAX_SHIFT(26)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s1),
        .a(a), .b(b), .out_valid(out_valid_s1), .out_ready(out_ready),
        .large_n(large_n_s1), .small_n(small_n_s1), .bit_r(bit_r_s1),
        .e(e_s1), .special(special_s1)
    );

    fp_unpack_align #(.STEP(4), .MAX_SHIFT(26)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s4),
        .a(a), .b(b), .out_valid(out_valid_s4), .out_ready(out_ready),
        .large_n(large_n_s4), .small_n(small_n_s4), .bit_r(bit_r_s4),
        .e(e_s4), .special(special_s4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latencies count clock edges from the accept edge inclusive to the edge raising out_valid.
    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [25:0] x_large, input logic [25:0] x_small,
                          input logic [7:0] x_e, input logic x_r, input logic x_sp,
                          input int lat1, input int lat4);
        int n = 1;
        int got1 = 0, got4 = 0;
        logic [25:0] l1 = '0, s1 = '0, l4 = '0, s4 = '0;
        logic [7:0]  e1 = '0, e4 = '0;
        logic        r1 = 1'b0, r4 = 1'b0, p1 = 1'b0, p4 = 1'b0;
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, {31'd0, in_ready_s1}, 32'd0);
        while ((got1 == 0 || got4 == 0) && n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid_s1 && got1 == 0) begin
                got1 = n; l1 = large_n_s1; s1 = small_n_s1; e1 = e_s1; r1 = bit_r_s1; p1 = special_s1;
            end
            if (out_valid_s4 && got4 == 0) begin
                got4 = n; l4 = large_n_s4; s4 = small_n_s4; e4 = e_s4; r4 = bit_r_s4; p4 = special_s4;
            end
        end
        chk({tag, "_lat_s1"},   got1, lat1);
        chk({tag, "_lat_s4"},   got4, lat4);
        chk({tag, "_large_s1"}, {6'd0, l1}, {6'd0, x_large});
        chk({tag, "_small_s1"}, {6'd0, s1}, {6'd0, x_small});
        chk({tag, "_e_s1"},     {24'd0, e1}, {24'd0, x_e});
        chk({tag, "_r_s1"},     {31'd0, r1}, {31'd0, x_r});
        chk({tag, "_sp_s1"},    {31'd0, p1}, {31'd0, x_sp});
        chk({tag, "_large_s4"}, {6'd0, l4}, {6'd0, x_large});
        chk({tag, "_small_s4"}, {6'd0, s4}, {6'd0, x_small});
        chk({tag, "_e_s4"},     {24'd0, e4}, {24'd0, x_e});
        chk({tag, "_r_s4"},     {31'd0, r4}, {31'd0, x_r});
        chk({tag, "_sp_s4"},    {31'd0, p4}, {31'd0, x_sp});
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #12;
        chk("rst_in_ready",  {31'd0, in_ready_s1},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid_s1}, 32'd0);
        chk("rst_large_n",   {6'd0, large_n_s1},    32'd0);
        chk("rst_small_n",   {6'd0, small_n_s1},    32'd0);
        chk("rst_e_r_sp",    {22'd0, e_s1, bit_r_s1, special_s1}, 32'd0);
        chk("rst_s4_ctrl",   {30'd0, in_ready_s4, out_valid_s4}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("one_one",  32'h3F800000, 32'h3F800000, 26'h1000000, 26'h1000000, 8'h7F, 1'b0, 1'b0, 2, 2);
        run_op("neg_small", 32'hBF800000, 32'h40000000, 26'h1000000, 26'h3800000, 8'h80, 1'b0, 1'b0, 3, 3);
        run_op("neg_large", 32'hC0000000, 32'h3F800000, 26'h3000000, 26'h0800000, 8'h80, 1'b0, 1'b0, 3, 3);
        run_op("d23",      32'h4B000000, 32'h3F800001, 26'h1000000, 26'h0000002, 8'h96, 1'b1, 1'b0, 25, 8);
        run_op("d31_cap",  32'h4F000000, 32'h3F800000, 26'h1000000, 26'h0000000, 8'h9E, 1'b1, 1'b0, 28, 9);
        run_op("denorm",   32'h00000000, 32'h00400000, 26'h0800000, 26'h0000000, 8'h01, 1'b0, 1'b0, 2, 2);
        run_op("inf",      32'h7F800000, 32'h3F800000, 26'h1000000, 26'h0000000, 8'hFF, 1'b1, 1'b1, 28, 9);

        // Backpressure: results held, new operands refused until the transfer.
        out_ready = 1'b0;
        run_op("bp",       32'h3F800000, 32'h3F800000, 26'h1000000, 26'h1000000, 8'h7F, 1'b0, 1'b0, 2, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 32'h40000000; b = 32'hBF800000; in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {30'd0, out_valid_s1, out_valid_s4}, 32'd3);
            chk("bp_hold_ready", {30'd0, in_ready_s1, in_ready_s4}, 32'd0);
            chk("bp_hold_large", {6'd0, large_n_s1}, 32'h1000000);
            chk("bp_hold_small", {6'd0, small_n_s4}, 32'h1000000);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", {30'd0, out_valid_s1, out_valid_s4}, 32'd0);
        chk("bp_release_ready", {30'd0, in_ready_s1, in_ready_s4}, 32'd3);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid_s1 || out_valid_s4) seen = 1;
        end
        chk("bp_no_accept", seen, 0);

        // Reset in the middle of a long alignment drops the pair.
        @(negedge clk);
        a = 32'h4F000000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {30'd0, out_valid_s1, out_valid_s4}, 32'd0);
        chk("mid_rst_ready", {30'd0, in_ready_s1, in_ready_s4}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid_s1 || out_valid_s4) seen = 1;
        end
        chk("mid_rst_no_out", seen, 0);
        run_op("post_rst", 32'h3F800000, 32'h3F800000, 26'h1000000, 26'h1000000, 8'h7F, 1'b0, 1'b0, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
